adder_result_reg: RTL and testbench

ADDER_RESULT_REG -- requirements
Module: adder_result_reg

---
 rtl/adder_result_reg.sv | 122 ++++++++++++
 tb/tb_adder_result_reg.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/adder_result_reg.sv
`default_nettype none
// ============================================================================
//  Module      : adder_result_reg
//  Description : Two-entry result buffer for a WIDTH-bit ripple adder. Each
//                accepted adder result is stored together with its status
//                flags {V,C,Z,N}. The head entry is presented through a
//                valid/ready output port. A result that arrives while the
//                buffer is full and not draining is lost, and the sticky
//                overrun flag is raised.
//  Ports       : clk, rst (async, active-high)
//                in_valid/in_ready  - input handshake
//                sum, cout          - adder outputs
//                a_msb, b_msb       - operand sign bits for overflow detection
//                out_valid/out_ready- output handshake
//                out_sum, out_flags - head entry {V,C,Z,N}
//                overrun            - sticky "result lost" flag
//                count              - occupied entries (0..2)
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_result_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  input  logic             a_msb,
  input  logic             b_msb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [3:0]       out_flags,
  output logic             overrun,
  output logic [1:0]       count
);

  // Occupancy state doubles as the entry count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  occ_e             occ_q, occ_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             overrun_q, overrun_d;
  logic [WIDTH+3:0] mem_q [2];

  logic             w_push;
  logic             w_pop;
  logic [3:0]       w_flags;

  // Flags are captured with the data so they travel through the buffer
  // alongside the sum they describe.
  assign w_flags[0] = sum[WIDTH-1];
  assign w_flags[1] = (sum == '0);
  assign w_flags[2] = cout;
  assign w_flags[3] = (a_msb == b_msb) && (sum[WIDTH-1] != a_msb);

  // A full buffer can still accept when the head leaves in the same cycle.
  assign in_ready  = (occ_q != FULL) || out_ready;
  assign out_valid = (occ_q != EMPTY);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  assign count     = occ_q;
  assign overrun   = overrun_q;
  assign out_sum   = mem_q[rd_ptr_q][WIDTH-1:0];
  assign out_flags = mem_q[rd_ptr_q][WIDTH+3:WIDTH];

  always_comb begin
    occ_d     = occ_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    overrun_d = overrun_q;

    if (w_push) wr_ptr_d = ~wr_ptr_q;
    if (w_pop)  rd_ptr_d = ~rd_ptr_q;
    if (in_valid && !in_ready) overrun_d = 1'b1;

    case (occ_q)
      EMPTY: if (w_push) occ_d = ONE;
      ONE: begin
        if (w_push && !w_pop)      occ_d = FULL;
        else if (!w_push && w_pop) occ_d = EMPTY;
      end
      FULL:  if (w_pop && !w_push) occ_d = ONE;
      default: occ_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q     <= EMPTY;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      occ_q     <= occ_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      overrun_q <= overrun_d;
    end
  end

  // Entries are cleared on reset so the outputs read zero while rst is high.
  // When full with a simultaneous pop, the write slot equals the read slot:
  // the head is consumed this cycle and the new entry lands behind the other.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (w_push) begin
      mem_q[wr_ptr_q] <= {w_flags, sum};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adder_result_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adder_result_reg
//  Description : Self-checking bench for adder_result_reg. A queue-based
//                reference model derives expected outputs from operand
//                arithmetic (signed overflow, carry out, zero, sign).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_result_reg;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             a_msb;
  logic             b_msb;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic [3:0]       out_flags;
  logic             overrun;
  logic [1:0]       count;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: FIFO of {flags, sum} plus sticky overrun.
  logic [7:0] mq[$];
  logic       m_ovr;

  always #5 clk = ~clk;

  adder_result_reg #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sum      (sum),
    .cout     (cout),
    .a_msb    (a_msb),
    .b_msb    (b_msb),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_flags(out_flags),
    .overrun  (overrun),
    .count    (count)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected entry from the operands using plain integer arithmetic.
  function automatic logic [7:0] model_entry(input logic [3:0] a, input logic [3:0] b);
    int          u;
    int          s;
    logic [3:0]  r;
    logic [3:0]  f;
    u = int'(a) + int'(b);
    s = int'($signed(a)) + int'($signed(b));
    r = u[3:0];
    f[3] = (s > 7) || (s < -8);
    f[2] = (u > 15);
    f[1] = (r == 4'd0);
    f[0] = (r >= 4'd8);
    return {f, r};
  endfunction

  // Compare all observable outputs with the model for the current cycle.
  task automatic check_all(input string tag);
    chk({tag, ".count"},     {6'd0, count},     8'(mq.size()));
    chk({tag, ".out_valid"}, {7'd0, out_valid}, {7'd0, (mq.size() != 0)});
    chk({tag, ".in_ready"},  {7'd0, in_ready},  {7'd0, (mq.size() < 2) || out_ready});
    chk({tag, ".overrun"},   {7'd0, overrun},   {7'd0, m_ovr});
    if (mq.size() != 0) begin
      chk({tag, ".out_sum"},   {4'd0, out_sum},   {4'd0, mq[0][3:0]});
      chk({tag, ".out_flags"}, {4'd0, out_flags}, {4'd0, mq[0][7:4]});
    end
  endtask

  // One clock cycle: drive at negedge, check before the rising edge, then
  // advance the model across the edge.
  task automatic step(input string tag, input logic v, input logic [3:0] a,
                      input logic [3:0] b, input logic ordy);
    logic [4:0] full;
    logic       rdy;
    logic       do_pop;
    logic       do_push;
    @(negedge clk);
    full      = {1'b0, a} + {1'b0, b};
    in_valid  = v;
    sum       = full[3:0];
    cout      = full[4];
    a_msb     = a[3];
    b_msb     = b[3];
    out_ready = ordy;
    #1;
    check_all(tag);
    rdy     = (mq.size() < 2) || ordy;
    do_pop  = ordy && (mq.size() != 0);
    do_push = v && rdy;
    @(posedge clk);
    if (do_pop)     void'(mq.pop_front());
    if (do_push)    mq.push_back(model_entry(a, b));
    if (v && !rdy)  m_ovr = 1'b1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; sum = '0; cout = 1'b0;
    a_msb = 1'b0; b_msb = 1'b0; out_ready = 1'b0;
    m_ovr = 1'b0;

    // Reset values while rst is held.
    #3;
    chk("rst.count",     {6'd0, count},     8'd0);
    chk("rst.out_valid", {7'd0, out_valid}, 8'd0);
    chk("rst.in_ready",  {7'd0, in_ready},  8'd1);
    chk("rst.overrun",   {7'd0, overrun},   8'd0);
    chk("rst.out_sum",   {4'd0, out_sum},   8'd0);
    chk("rst.out_flags", {4'd0, out_flags}, 8'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Single pushes with explicit flag patterns.
    step("p1", 1'b1, 4'b0010, 4'b1101, 1'b1);
    step("p1c", 1'b0, 4'd0, 4'd0, 1'b0);
    chk("req32.sum",   {4'd0, out_sum},   8'b0000_1111);
    chk("req32.flags", {4'd0, out_flags}, 8'b0000_0001);
    step("p2", 1'b1, 4'b1000, 4'b1101, 1'b1);
    step("p2c", 1'b0, 4'd0, 4'd0, 1'b0);
    chk("req33.sum",   {4'd0, out_sum},   8'b0000_0101);
    chk("req33.flags", {4'd0, out_flags}, 8'b0000_1100);
    step("p3", 1'b1, 4'b0011, 4'b1101, 1'b1);
    step("p3c", 1'b0, 4'd0, 4'd0, 1'b0);
    chk("req34.sum",   {4'd0, out_sum},   8'b0000_0000);
    chk("req34.flags", {4'd0, out_flags}, 8'b0000_0110);
    step("drain", 1'b0, 4'd0, 4'd0, 1'b1);

    // Fill, overrun, then ordered drain.
    step("f1", 1'b1, 4'b0111, 4'b1000, 1'b0);
    step("f2", 1'b1, 4'b0101, 4'b0110, 1'b0);
    step("f3", 1'b1, 4'b0001, 4'b0001, 1'b0);
    step("f4", 1'b0, 4'd0, 4'd0, 1'b0);
    chk("req35.overrun", {7'd0, overrun}, 8'd1);
    chk("req35.count",   {6'd0, count},   8'd2);
    step("d1", 1'b0, 4'd0, 4'd0, 1'b1);
    step("d2", 1'b0, 4'd0, 4'd0, 1'b1);
    step("d3", 1'b0, 4'd0, 4'd0, 1'b1);

    // Full buffer streaming: push and pop together for 4 cycles.
    rst = 1'b1; #1; rst = 1'b0; mq.delete(); m_ovr = 1'b0;
    step("s1", 1'b1, 4'd1, 4'd2, 1'b0);
    step("s2", 1'b1, 4'd3, 4'd4, 1'b0);
    for (int i = 0; i < 4; i++)
      step("stream", 1'b1, 4'(i + 5), 4'(i * 3), 1'b1);
    step("s3", 1'b0, 4'd0, 4'd0, 1'b0);
    chk("req36.count",   {6'd0, count},   8'd2);
    chk("req36.overrun", {7'd0, overrun}, 8'd0);

    // Async reset between edges with 2 entries and overrun set.
    step("o1", 1'b1, 4'd9, 4'd9, 1'b0);
    step("o2", 1'b0, 4'd0, 4'd0, 1'b0);
    @(posedge clk); #2;
    rst = 1'b1; #1;
    chk("areset.out_valid", {7'd0, out_valid}, 8'd0);
    chk("areset.count",     {6'd0, count},     8'd0);
    chk("areset.overrun",   {7'd0, overrun},   8'd0);
    chk("areset.in_ready",  {7'd0, in_ready},  8'd1);
    mq.delete(); m_ovr = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // First push after reset is accepted on the first edge.
    step("post_rst", 1'b1, 4'd6, 4'd7, 1'b0);
    step("post_rst_c", 1'b0, 4'd0, 4'd0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 300; i++)
      step("rand", 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom),
           1'($urandom_range(0, 1)));
    step("final", 1'b0, 4'd0, 4'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
